// File: rtl/ofdm_tx_framer.sv
// ofdm_tx_framer: buffers the cyclic-prefixed complex sample stream in a FIFO.
// It narrows each sample to the DAC width and emits whole symbols with
// sop/eop markers, followed by GUARD_LEN zero guard beats.
// Optional build macro: OFDM_FRAMER_SAT_EN.
//   Defined:   narrowing saturates and sets sat_hit.
//   Undefined: narrowing wraps and sat_hit stays 0.
module ofdm_tx_framer #(
  parameter int Data_Width = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0,
  parameter int SYMBOL_LEN = 10,
  parameter int GUARD_LEN  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic signed [Data_Width-1:0]       in_real,
  input  logic signed [Data_Width-1:0]       in_imag,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [OUT_WIDTH-1:0]        out_real,
  output logic signed [OUT_WIDTH-1:0]        out_imag,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic                               out_guard,
  output logic                               overflow,
  output logic                               sat_hit,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SYMBOL_LEN + GUARD_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] START_LVL  = LW'(SYMBOL_LEN);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(SYMBOL_LEN - 1);
  localparam logic [CW-1:0] LAST_GUARD = CW'(GUARD_LEN - 1);

`ifdef OFDM_FRAMER_SAT_EN
  localparam logic signed [Data_Width-1:0] SAT_MAX =
    {{(Data_Width-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [Data_Width-1:0] SAT_MIN =
    {{(Data_Width-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

  // Returns {clamped_flag, narrowed_sample}.
  function automatic logic [OUT_WIDTH:0] narrow(input logic signed [Data_Width-1:0] x);
`ifdef OFDM_FRAMER_SAT_EN
    logic signed [Data_Width-1:0] sh;
    sh = x >>> SHIFT;
    if (sh > SAT_MAX)      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (sh < SAT_MIN) return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                   return {1'b0, sh[OUT_WIDTH-1:0]};
`else
    return {1'b0, OUT_WIDTH'(x >>> SHIFT)};
`endif
  endfunction

  logic [OUT_WIDTH-1:0] mem_re [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_im [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [OUT_WIDTH:0]   nar_re, nar_im;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic                 push, pop;

  // There is no pass-through when full: in_ready comes only from the registered level.
  assign in_ready   = (fifo_level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_DATA) && out_ready;
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign nar_re     = narrow(in_real);
  assign nar_im     = narrow(in_imag);

  // Sample storage; entries are only read after being written.
  // NOTE: the memory has no reset, so it maps onto plain RAM/regfile cells; occupancy tracking alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_re[wr_ptr] <= nar_re[OUT_WIDTH-1:0];
      mem_im[wr_ptr] <= nar_im[OUT_WIDTH-1:0];
    end
  end

  // FIFO pointers, occupancy and the sticky status flags.
  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      sat_hit    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (push && (nar_re[OUT_WIDTH] || nar_im[OUT_WIDTH])) sat_hit <= 1'b1;
    end
  end

  // Output FSM: registered beats; state only advances on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_guard <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_level >= START_LVL) begin
            state     <= S_DATA;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= (LAST_BEAT == '0);
            out_real  <= $signed(mem_re[rd_ptr]);
            out_imag  <= $signed(mem_im[rd_ptr]);
          end
        end
        S_DATA: begin
          if (out_ready) begin
            out_sop <= 1'b0;
            if (cnt == LAST_BEAT) begin
              cnt      <= '0;
              out_eop  <= 1'b0;
              out_real <= '0;
              out_imag <= '0;
              if (GUARD_LEN > 0) begin
                state     <= S_GUARD;
                out_guard <= 1'b1;
              end else begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              cnt      <= cnt + CW'(1);
              out_eop  <= ((cnt + CW'(1)) == LAST_BEAT);
              out_real <= $signed(mem_re[rd_ptr_nxt]);
              out_imag <= $signed(mem_im[rd_ptr_nxt]);
            end
          end
        end
        S_GUARD: begin
          if (out_ready) begin
            if (cnt == LAST_GUARD) begin
              state     <= S_IDLE;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_guard <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// Self-checking bench for ofdm_tx_framer (default parameters).
// Accepted input samples push expected beats (data plus guard) onto a scoreboard.
// Handshaked output beats pop the scoreboard and are compared against it.
module tb_ofdm_tx_framer;

  localparam int SYM = 10;
  localparam int GRD = 2;

`ifdef OFDM_FRAMER_SAT_EN
  localparam int EXP_BIG_RE = 32767;
  localparam int EXP_BIG_IM = -32768;
  localparam int EXP_SAT    = 1;
`else
  localparam int EXP_BIG_RE = -25536;
  localparam int EXP_BIG_IM = 25536;
  localparam int EXP_SAT    = 0;
`endif

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               sop;
    logic               eop;
    logic               guard;
  } beat_t;

  logic               clk, rst;
  logic               in_valid, in_ready;
  logic signed [31:0] in_real, in_imag;
  logic               out_valid, out_ready;
  logic signed [15:0] out_real, out_imag;
  logic               out_sop, out_eop, out_guard;
  logic               overflow, sat_hit;
  logic [4:0]         fifo_level;

  beat_t sb[$];
  int    sym_idx = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  ofdm_tx_framer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_sop(out_sop), .out_eop(out_eop), .out_guard(out_guard),
    .overflow(overflow), .sat_hit(sat_hit), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] model_narrow(input int x);
`ifdef OFDM_FRAMER_SAT_EN
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
`endif
    return 16'(x);
  endfunction

  // Scoreboard: pop on output handshake, push on input accept.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
      sym_idx = 0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("beat_re", out_real, e.re);
          check("beat_im", out_imag, e.im);
          check("beat_sop", out_sop, e.sop);
          check("beat_eop", out_eop, e.eop);
          check("beat_guard", out_guard, e.guard);
        end
      end
      if (in_valid && in_ready) begin
        e.re    = model_narrow(in_real);
        e.im    = model_narrow(in_imag);
        e.sop   = (sym_idx == 0);
        e.eop   = (sym_idx == SYM - 1);
        e.guard = 1'b0;
        sb.push_back(e);
        sym_idx++;
        if (sym_idx == SYM) begin
          sym_idx = 0;
          for (int g = 0; g < GRD; g++) begin
            e = '{re: 16'sd0, im: 16'sd0, sop: 1'b0, eop: 1'b0, guard: 1'b1};
            sb.push_back(e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int re, input int im);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input logic v, input string tag);
    int n = 0;
    while (out_valid !== v && n < 50) begin
      step();
      n++;
    end
    check(tag, out_valid, v);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
    wait_valid(1'b0, {tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_real = 0; in_imag = 0; out_ready = 1'b0;

    // Reset check
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_guard", out_guard, 0);
    check("rst_re", out_real, 0);
    check("rst_im", out_imag, 0);
    check("rst_ovf", overflow, 0);
    check("rst_sat", sat_hit, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);

    // Single symbol with latency and symbol length
    out_ready = 1'b1;
    for (int k = 0; k < SYM; k++) push(k, -k);
    check("lat_level", fifo_level, 10);
    check("lat_valid_lo", out_valid, 0);
    step();
    check("lat_valid_hi", out_valid, 1);
    check("lat_sop", out_sop, 1);
    check("lat_re0", out_real, 0);
    n = 0;
    while (out_valid && n < 40) begin
      step();
      n++;
    end
    check("sym_cycles", n, SYM + GRD);
    check("sym_sb_empty", sb.size(), 0);

    // Backpressure at beat 4
    for (int k = 0; k < SYM; k++) push(k, -k);
    wait_valid(1'b1, "bp_start");
    repeat (4) step();
    check("bp_beat4", out_real, 4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_re", out_real, 4);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_level", fifo_level, 6);
      step();
    end
    out_ready = 1'b1;
    drain("bp_drain");

    // Overflow with the sink stalled
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) push(200 + k, -(200 + k));
    check("ovf_ready16", in_ready, 0);
    check("ovf_level16", fifo_level, 16);
    check("ovf_flag16", overflow, 0);
    push(216, -216);
    check("ovf_flag17", overflow, 1);
    check("ovf_level17", fifo_level, 16);
    out_ready = 1'b1;
    step();
    for (int k = 17; k < 21; k++) push(200 + k, -(200 + k));
    drain("ovf_drain");

    // Narrowing
    push(40000, -40000);
    check("nar_sat_hit", sat_hit, EXP_SAT);
    for (int k = 1; k < SYM; k++) push(k, -k);
    wait_valid(1'b1, "nar_start");
    check("nar_sop", out_sop, 1);
    check("nar_re", out_real, EXP_BIG_RE);
    check("nar_im", out_imag, EXP_BIG_IM);
    drain("nar_drain");

    // Reset mid-symbol
    for (int k = 0; k < SYM; k++) push(k, -k);
    wait_valid(1'b1, "mid_start");
    repeat (5) step();
    check("mid_beat5", out_real, 5);
    rst = 1'b1;
    step();
    check("mid_valid", out_valid, 0);
    check("mid_level", fifo_level, 0);
    check("mid_ovf", overflow, 0);
    check("mid_sat", sat_hit, 0);
    check("mid_sop", out_sop, 0);
    rst = 1'b0;
    check("mid_ready", in_ready, 1);
    for (int k = 0; k < SYM; k++) push(300 + k, -(300 + k));
    wait_valid(1'b1, "fresh_start");
    check("fresh_sop", out_sop, 1);
    check("fresh_re", out_real, 300);
    drain("fresh_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
